// File: rtl/cosmem_pkg.sv
// Shared Cosmem definitions: requester ownership encoding, default RAM depth
// and the byte returned for reads that fall outside the RAM.
package cosmem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        HOST = 2'd2
    } owner_t;

    localparam int         COSMEM_DEF_WORDS = 8192;
    localparam logic [7:0] COSMEM_OOB_RDATA = 8'hFF;

endpackage

// File: rtl/cosmem_sched_if.sv
// RAM scheduler bus bundle: CPU port, host/loader port, COSMAC wait line and
// the single block-RAM port. The scheduler uses slave, its surroundings master.
interface cosmem_sched_if import cosmem_pkg::*; #(
    parameter int ADDR_W = 13
) ();

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [7:0]        c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [7:0]        c_rdata;

    logic              h_valid;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_wdata;
    logic              h_ready;
    logic              h_rvalid;
    logic [7:0]        h_rdata;
    logic              h_lock;

    logic              nwait;
    owner_t            last_grant;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  h_valid, h_we, h_addr, h_wdata, h_lock,
        output h_ready, h_rvalid, h_rdata,
        output nwait, last_grant,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output h_valid, h_we, h_addr, h_wdata, h_lock,
        input  h_ready, h_rvalid, h_rdata,
        input  nwait, last_grant,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/cosmem_sched_starve.sv
// Host starvation guard: counts consecutive cycles the host waits and raises
// forceHost_o once the count reaches HOST_STARVE, handing the host one grant.
module cosmem_sched_starve #(
    parameter int HOST_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic hValid_i,
    input  logic hReady_i,
    output logic forceHost_o
);

    localparam logic [3:0] LIMIT = 4'(HOST_STARVE);

    logic [3:0] starveCnt_q;
    logic [3:0] starveCnt_d;

    always_comb begin
        starveCnt_d = 4'd0;
        if (hValid_i && !hReady_i) begin
            starveCnt_d = (starveCnt_q == 4'hF) ? 4'hF : starveCnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt_q <= 4'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    // Depends only on the registered count so it cannot loop through hReady_i.
    assign forceHost_o = hValid_i && (starveCnt_q == LIMIT);

endmodule

// File: rtl/cosmem_sched.sv
// Single-port block-RAM scheduler sharing the RAM between the COSMAC (priority)
// and the host loader. Optional starvation guard: COSMEM_SCHED_STARVE_EN.
module cosmem_sched import cosmem_pkg::*; #(
    parameter int MEM_WORDS   = COSMEM_DEF_WORDS,
    parameter int ADDR_W      = $clog2(MEM_WORDS),
    parameter int HOST_STARVE = 4
) (
    input  logic           clk,
    input  logic           reset,
    cosmem_sched_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_WORDS);

    logic       forceHost;
    logic       cpuGnt;
    logic       hostGnt;
    logic       cpuInRange;
    logic       hostInRange;
    logic [7:0] retData;

    owner_t rdOwner_q, rdOwner_d;
    owner_t lastGrant_q, lastGrant_d;
    logic   rdOob_q, rdOob_d;
    logic   nwait_q, nwait_d;

`ifdef COSMEM_SCHED_STARVE_EN
    cosmem_sched_starve #(
        .HOST_STARVE (HOST_STARVE)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .hValid_i    (bus.h_valid),
        .hReady_i    (hostGnt),
        .forceHost_o (forceHost)
    );
`else
    assign forceHost = 1'b0;
`endif

    assign cpuInRange  = {1'b0, bus.c_addr} < DEPTH;
    assign hostInRange = {1'b0, bus.h_addr} < DEPTH;

    always_comb begin
        cpuGnt  = !reset && bus.c_req && !bus.h_lock && !forceHost;
        hostGnt = !reset && bus.h_valid && !cpuGnt;
    end

    // Out-of-range accesses are still granted but never reach the RAM.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'h00;
        if (cpuGnt) begin
            bus.mem_en    = cpuInRange;
            bus.mem_we    = bus.c_we && cpuInRange;
            bus.mem_addr  = bus.c_addr;
            bus.mem_wdata = bus.c_wdata;
        end else if (hostGnt) begin
            bus.mem_en    = hostInRange;
            bus.mem_we    = bus.h_we && hostInRange;
            bus.mem_addr  = bus.h_addr;
            bus.mem_wdata = bus.h_wdata;
        end
    end

    always_comb begin
        rdOwner_d   = NONE;
        lastGrant_d = NONE;
        rdOob_d     = 1'b0;
        if (cpuGnt) begin
            lastGrant_d = CPU;
            if (!bus.c_we) begin
                rdOwner_d = CPU;
                rdOob_d   = !cpuInRange;
            end
        end else if (hostGnt) begin
            lastGrant_d = HOST;
            if (!bus.h_we) begin
                rdOwner_d = HOST;
                rdOob_d   = !hostInRange;
            end
        end
        nwait_d = !(bus.c_req && !cpuGnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdOwner_q   <= NONE;
            lastGrant_q <= NONE;
            rdOob_q     <= 1'b0;
            nwait_q     <= 1'b1;
        end else begin
            rdOwner_q   <= rdOwner_d;
            lastGrant_q <= lastGrant_d;
            rdOob_q     <= rdOob_d;
            nwait_q     <= nwait_d;
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived.
    assign retData      = rdOob_q ? COSMEM_OOB_RDATA : bus.mem_rdata;
    assign bus.c_rvalid = !reset && (rdOwner_q == CPU);
    assign bus.h_rvalid = !reset && (rdOwner_q == HOST);
    assign bus.c_rdata  = bus.c_rvalid ? retData : 8'h00;
    assign bus.h_rdata  = bus.h_rvalid ? retData : 8'h00;

    assign bus.c_gnt      = cpuGnt;
    assign bus.h_ready    = hostGnt;
    assign bus.nwait      = nwait_q;
    assign bus.last_grant = lastGrant_q;

endmodule

// File: tb/tb_cosmem_sched.sv
// Self-checking bench for cosmem_sched: directed scenarios plus random traffic
// compared against a behavioural arbitration/memory model.
module tb_cosmem_sched;

    localparam int HOST_STARVE = 4;
`ifdef COSMEM_SCHED_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    int assertCount = 0;
    int failCount   = 0;

    cosmem_sched_if #(.ADDR_W(13)) bus ();
    cosmem_sched_if #(.ADDR_W(13)) oobBus ();

    cosmem_sched #(
        .MEM_WORDS   (8192),
        .ADDR_W      (13),
        .HOST_STARVE (HOST_STARVE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cosmem_sched #(
        .MEM_WORDS   (6000),
        .ADDR_W      (13),
        .HOST_STARVE (HOST_STARVE)
    ) dutOob (
        .clk   (clk),
        .reset (reset),
        .bus   (oobBus)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in for the main instance: one-cycle read latency.
    logic [7:0] ramArr [8192];
    logic [7:0] ramQ = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ramArr[bus.mem_addr] <= bus.mem_wdata;
            else            ramQ <= ramArr[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ramQ;

    logic [7:0] oobRdata = 8'h3C;
    assign oobBus.mem_rdata = oobRdata;

    // Reference model state.
    logic [7:0] refMem [8192];
    int         pendOwner  = 0;
    logic [7:0] pendData   = 8'h00;
    bit         prevDenied = 1'b0;
    int         starveCnt  = 0;
    int         prevGrant  = 0;
    bit         lastECGnt  = 1'b0;
    bit         lastEHRdy  = 1'b0;

    // Observed values of the most recent cycle, for scenario-level checks.
    logic       obsCGnt, obsHRdy, obsCRvalid, obsHRvalid, obsNwait;
    logic [7:0] obsCRdata, obsHRdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit cReq, input bit cWe,
                                 input logic [12:0] cAddr, input logic [7:0] cWdata,
                                 input bit hValid, input bit hWe,
                                 input logic [12:0] hAddr, input logic [7:0] hWdata,
                                 input bit hLock);
        bit          forceH, eCGnt, eHRdy, eCRv, eHRv;
        logic [12:0] eAddr;
        logic [7:0]  eWdata;
        reset       = rst;
        bus.c_req   = cReq;
        bus.c_we    = cWe;
        bus.c_addr  = cAddr;
        bus.c_wdata = cWdata;
        bus.h_valid = hValid;
        bus.h_we    = hWe;
        bus.h_addr  = hAddr;
        bus.h_wdata = hWdata;
        bus.h_lock  = hLock;
        #4;
        forceH = STARVE_ON && hValid && (starveCnt == HOST_STARVE);
        eCGnt  = !rst && cReq && !hLock && !forceH;
        eHRdy  = !rst && hValid && !eCGnt;
        eCRv   = !rst && (pendOwner == 1);
        eHRv   = !rst && (pendOwner == 2);
        eAddr  = eCGnt ? cAddr  : (eHRdy ? hAddr  : 13'd0);
        eWdata = eCGnt ? cWdata : (eHRdy ? hWdata : 8'h00);

        checkOutput("c_gnt",      bus.c_gnt,    eCGnt);
        checkOutput("h_ready",    bus.h_ready,  eHRdy);
        checkOutput("c_rvalid",   bus.c_rvalid, eCRv);
        checkOutput("h_rvalid",   bus.h_rvalid, eHRv);
        checkOutput("c_rdata",    bus.c_rdata,  eCRv ? pendData : 8'h00);
        checkOutput("h_rdata",    bus.h_rdata,  eHRv ? pendData : 8'h00);
        checkOutput("nwait",      bus.nwait,    !prevDenied);
        checkOutput("mem_en",     bus.mem_en,   eCGnt || eHRdy);
        checkOutput("mem_we",     bus.mem_we,   (eCGnt && cWe) || (eHRdy && hWe));
        checkOutput("mem_addr",   bus.mem_addr, eAddr);
        checkOutput("mem_wdata",  bus.mem_wdata, eWdata);
        checkOutput("last_grant", 32'(bus.last_grant), prevGrant);

        obsCGnt    = bus.c_gnt;
        obsHRdy    = bus.h_ready;
        obsCRvalid = bus.c_rvalid;
        obsHRvalid = bus.h_rvalid;
        obsCRdata  = bus.c_rdata;
        obsHRdata  = bus.h_rdata;
        obsNwait   = bus.nwait;

        lastECGnt = eCGnt;
        lastEHRdy = eHRdy;
        if (rst) begin
            pendOwner  = 0;
            prevDenied = 1'b0;
            starveCnt  = 0;
            prevGrant  = 0;
        end else begin
            pendOwner = 0;
            prevGrant = eCGnt ? 1 : (eHRdy ? 2 : 0);
            if (eCGnt) begin
                if (cWe) refMem[cAddr] = cWdata;
                else begin pendOwner = 1; pendData = refMem[cAddr]; end
            end else if (eHRdy) begin
                if (hWe) refMem[hAddr] = hWdata;
                else begin pendOwner = 2; pendData = refMem[hAddr]; end
            end
            prevDenied = cReq && !eCGnt;
            starveCnt  = (hValid && !eHRdy) ? ((starveCnt >= 15) ? 15 : starveCnt + 1) : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rst);
        applyStimulus(rst, 0, 0, 13'd0, 8'h00, 0, 0, 13'd0, 8'h00, 0);
    endtask

    initial begin
        int          cpuGrants, hostGrants, firstHost;
        logic        nwaitLock [3];
        logic        nwaitStarve [10];
        bit          cReq, cWe, hValid, hWe, hLock, rst;
        logic [12:0] cAddr, hAddr;
        logic [7:0]  cWdata, hWdata;

        reset = 1'b1;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.h_valid = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0; bus.h_lock = 0;
        oobBus.c_req = 0; oobBus.c_we = 0; oobBus.c_addr = '0; oobBus.c_wdata = '0;
        oobBus.h_valid = 0; oobBus.h_we = 0; oobBus.h_addr = '0; oobBus.h_wdata = '0;
        oobBus.h_lock = 0;
        @(posedge clk);
        #1;
        $display("[TB] reset state");
        idle(1);
        checkOutput("rst_nwait", obsNwait, 1'b1);
        idle(1);

        // Preload through the host port so model and RAM agree.
        for (int i = 0; i < 64; i++)
            applyStimulus(0, 0, 0, 13'd0, 8'h00, 1, 1, 13'(i), 8'($urandom), 0);
        applyStimulus(0, 0, 0, 13'd0, 8'h00, 1, 1, 13'h200, 8'hC3, 0);
        applyStimulus(0, 0, 0, 13'd0, 8'h00, 1, 1, 13'h010, 8'h5A, 0);

        $display("[TB] cpu read 0x0010");
        applyStimulus(0, 1, 0, 13'h010, 8'h00, 0, 0, 13'd0, 8'h00, 0);
        checkOutput("t1_gnt", obsCGnt, 1'b1);
        idle(0);
        checkOutput("t1_rvalid", obsCRvalid, 1'b1);
        checkOutput("t1_rdata", obsCRdata, 8'h5A);
        checkOutput("t1_nwait", obsNwait, 1'b1);

        $display("[TB] simultaneous cpu write / host read");
        applyStimulus(0, 1, 1, 13'h100, 8'h11, 1, 0, 13'h200, 8'h00, 0);
        checkOutput("t2_cgnt", obsCGnt, 1'b1);
        checkOutput("t2_hwait", obsHRdy, 1'b0);
        applyStimulus(0, 0, 0, 13'd0, 8'h00, 1, 0, 13'h200, 8'h00, 0);
        checkOutput("t2_hrdy", obsHRdy, 1'b1);
        idle(0);
        checkOutput("t2_hrvalid", obsHRvalid, 1'b1);
        checkOutput("t2_hrdata", obsHRdata, 8'hC3);

        $display("[TB] host lock");
        cpuGrants = 0; hostGrants = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 13'h030, 8'h00, 1, 1, 13'(k), 8'(8'hA0 + k), 1);
            cpuGrants  += int'(obsCGnt);
            hostGrants += int'(obsHRdy);
            nwaitLock[k] = obsNwait;
        end
        checkOutput("t3_cpu_grants", cpuGrants, 0);
        checkOutput("t3_host_grants", hostGrants, 3);
        checkOutput("t3_nwait_c2", nwaitLock[1], 1'b0);
        applyStimulus(0, 1, 0, 13'h030, 8'h00, 0, 0, 13'd0, 8'h00, 0);
        checkOutput("t3_unlock_gnt", obsCGnt, 1'b1);
        checkOutput("t3_unlock_nwait", obsNwait, 1'b0);
        idle(0);
        checkOutput("t3_after_nwait", obsNwait, 1'b1);

        $display("[TB] reset during read");
        applyStimulus(0, 1, 0, 13'h020, 8'h00, 0, 0, 13'd0, 8'h00, 0);
        applyStimulus(1, 1, 0, 13'h021, 8'h00, 1, 0, 13'h022, 8'h00, 0);
        checkOutput("t4_rvalid", obsCRvalid, 1'b0);
        checkOutput("t4_nwait", obsNwait, 1'b1);
        checkOutput("t4_no_gnt", obsCGnt | obsHRdy, 1'b0);
        idle(0);

        $display("[TB] lock during outstanding read");
        applyStimulus(0, 1, 0, 13'h021, 8'h00, 0, 0, 13'd0, 8'h00, 0);
        applyStimulus(0, 1, 0, 13'h022, 8'h00, 0, 0, 13'd0, 8'h00, 1);
        checkOutput("t5_rvalid", obsCRvalid, 1'b1);
        checkOutput("t5_rdata", obsCRdata, refMem[13'h021]);
        applyStimulus(0, 1, 0, 13'h022, 8'h00, 0, 0, 13'd0, 8'h00, 0);
        idle(0);

        $display("[TB] starvation pattern");
        idle(1);
        hostGrants = 0; firstHost = -1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 0, 13'h022, 8'h00, 1, 0, 13'h023, 8'h00, 0);
            if (obsHRdy === 1'b1) begin
                hostGrants++;
                if (firstHost < 0) firstHost = k;
            end
            nwaitStarve[k] = obsNwait;
        end
        checkOutput("t6_host_grants", hostGrants, STARVE_ON ? 2 : 0);
        checkOutput("t6_first_host", firstHost, STARVE_ON ? 4 : -1);
        checkOutput("t6_nwait_c6", nwaitStarve[5], STARVE_ON ? 1'b0 : 1'b1);
        checkOutput("t6_nwait_c5", nwaitStarve[4], 1'b1);
        idle(0);

        $display("[TB] random traffic");
        cReq = 0; cWe = 0; cAddr = '0; cWdata = '0;
        hValid = 0; hWe = 0; hAddr = '0; hWdata = '0;
        for (int n = 0; n < 300; n++) begin
            if (!(cReq && !lastECGnt)) begin
                cReq   = ($urandom_range(0, 2) != 0);
                cWe    = $urandom_range(0, 1) == 1;
                cAddr  = 13'($urandom_range(0, 63));
                cWdata = 8'($urandom);
            end
            if (!(hValid && !lastEHRdy)) begin
                hValid = ($urandom_range(0, 1) == 1);
                hWe    = $urandom_range(0, 1) == 1;
                hAddr  = 13'($urandom_range(0, 63));
                hWdata = 8'($urandom);
            end
            hLock = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            applyStimulus(rst, cReq, cWe, cAddr, cWdata, hValid, hWe, hAddr, hWdata, hLock);
        end
        idle(0);

        $display("[TB] out-of-range depth 6000");
        oobBus.h_valid = 1; oobBus.h_we = 0; oobBus.h_addr = 13'd6000;
        #4;
        checkOutput("oob_rd_ready", oobBus.h_ready, 1'b1);
        checkOutput("oob_rd_men", oobBus.mem_en, 1'b0);
        @(posedge clk); #1;
        oobBus.h_addr = 13'd5999;
        #4;
        checkOutput("oob_rvalid", oobBus.h_rvalid, 1'b1);
        checkOutput("oob_rdata", oobBus.h_rdata, 8'hFF);
        checkOutput("inr_men", oobBus.mem_en, 1'b1);
        @(posedge clk); #1;
        oobBus.h_we = 1; oobBus.h_addr = 13'd6100; oobBus.h_wdata = 8'h77;
        #4;
        checkOutput("inr_rdata", oobBus.h_rdata, 8'h3C);
        checkOutput("oob_wr_ready", oobBus.h_ready, 1'b1);
        checkOutput("oob_wr_men", {oobBus.mem_en, oobBus.mem_we}, 2'b00);
        @(posedge clk); #1;
        oobBus.h_valid = 0; oobBus.h_we = 0;
        #4;
        checkOutput("oob_wr_no_rvalid", oobBus.h_rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cosmem_sched.md
# cosmem_sched

Single-port block-RAM scheduler for the Cosmem chip. It shares the one RAM port between two requesters: the COSMAC bus engine (CPU side, high priority) and a host/loader port used to preload and inspect memory. It drives the CPU wait line whenever a CPU access is deferred. It sits between the bus-cycle decoder and the block-RAM array inside `cosmem`.

## Interface
- `MEM_WORDS`, 8192: RAM depth in bytes.
- `ADDR_W`, `$clog2(MEM_WORDS)`: address width.
- `HOST_STARVE`, 4: consecutive denied host cycles before the host is forced through (1..15).

Ports:
- `clk` in 1: system clock (16 MHz).
- `reset` in 1: synchronous, active-high reset.
- `c_req` in 1: CPU access request, level, held until `c_gnt`.
- `c_we` in 1: CPU write when 1, read when 0.
- `c_addr` in ADDR_W: CPU byte address.
- `c_wdata` in 8: CPU write data.
- `c_gnt` out 1: CPU access issued this cycle.
- `c_rvalid` out 1: CPU read data valid.
- `c_rdata` out 8: CPU read data.
- `h_valid` in 1: host request; valid/ready handshake.
- `h_we` in 1: host write when 1.
- `h_addr` in ADDR_W: host address.
- `h_wdata` in 8: host write data.
- `h_ready` out 1: host access issued this cycle.
- `h_rvalid` out 1: host read data valid.
- `h_rdata` out 8: host read data.
- `h_lock` in 1: host halts the CPU; no CPU grants while high.
- `nwait` out 1: active-low wait to the COSMAC.
- `mem_en` out 1: RAM port enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid one cycle after `mem_en`.

## Operation
- Each cycle at most one requester is granted.
- `c_gnt` and `h_ready` are combinational from the current requests and registered state.
- `mem_*` mirror the granted requester in the same cycle.
- Default priority:
  - CPU wins if `c_req && !h_lock`.
  - Otherwise the host wins if `h_valid`.
- `h_lock` = 1: CPU requests are never granted; the host is granted on every `h_valid`.
- Registered state is `last_grant` (NONE/CPU/HOST), `rd_owner` (NONE/CPU/HOST) and the starve counter.
  - Grant of a read sets `rd_owner` to that requester for the next cycle.
  - A write grant, or no grant, sets `rd_owner` to NONE.
- Read return:
  - In the cycle after a granted read, the owner's `*_rvalid` = 1.
  - The owner's `*_rdata` = `mem_rdata`, passed through combinationally.
  - The non-owner's `*_rdata` holds 8'h00.
- Out-of-range address (`addr >= MEM_WORDS`, only possible when depth is not a power of 2):
  - The grant still occurs, but `mem_en` = 0.
  - A read returns 8'hFF with rvalid one cycle later.
  - A write is dropped.
- `nwait` is registered:
  - It goes 0 the cycle after any cycle with `c_req && !c_gnt`.
  - Otherwise it is 1.
- Back-to-back grants to the same requester are allowed every cycle; no turnaround bubble.

## Timing
- Reset values:
  - `c_gnt`, `h_ready`, `c_rvalid`, `h_rvalid`, `mem_en`, `mem_we` = 0.
  - `nwait` = 1.
  - `c_rdata`, `h_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `rd_owner`/`last_grant` = NONE; starve counter = 0.
- Grant latency is 0 cycles from request; read latency is 1 cycle from grant.
- Simultaneous `c_req` and `h_valid` (no lock, no starve) resolve as CPU granted, host waits.
- Reset asserted mid-read: the pending rvalid is suppressed in the following cycle and no grant is issued while `reset` is high.
- `h_lock` rising while a CPU read is outstanding: the read data still returns to the CPU the next cycle.

## Configuration
- `COSMEM_SCHED_STARVE_EN` defined:
  - A 4-bit counter increments each cycle `h_valid && !h_ready`; it clears on `h_ready` or when `h_valid` = 0.
  - When it equals `HOST_STARVE`, the host has priority for exactly one grant. The CPU is denied that cycle, so `nwait` drops for one cycle.
  - The counter saturates at 15.
- Undefined: strict CPU priority; the counter and forced grant are absent, and the host can starve indefinitely.

## Structure
- Shared package `cosmem_pkg`: the `owner_t` enum (NONE/CPU/HOST), `COSMEM_DEF_WORDS` = 8192, and the out-of-range read value 8'hFF.
- One natural sub-module, `cosmem_sched_starve`: starve counter and force flag, instantiated only under `COSMEM_SCHED_STARVE_EN`.

## Test plan
- CPU read at 0x0010 with RAM holding 0x5A:
  - `c_gnt` = 1 in the same cycle.
  - Next cycle `c_rvalid` = 1 and `c_rdata` = 0x5A.
  - `nwait` stays 1.
- Simultaneous `c_req` (write 0x0100 ← 0x11) and `h_valid` (read 0x0200):
  - CPU granted first, host granted next cycle.
  - `h_rdata` is valid 2 cycles after the requests.
- `h_lock` = 1 with `c_req` held for 3 cycles while the host writes 0x0000..0x0002:
  - 3 host grants, 0 CPU grants.
  - `nwait` = 0 from the 2nd cycle until one cycle after the lock drops, then the CPU is granted.
- With `COSMEM_SCHED_STARVE_EN` and `HOST_STARVE` = 4, `c_req` and `h_valid` held continuously:
  - Host granted on the 5th cycle.
  - `nwait` = 0 exactly one cycle later.
  - The pattern repeats every 5 cycles. Without the macro, the host is never granted.
- Reset asserted the cycle after a granted CPU read: `c_rvalid` stays 0 and `nwait` = 1.
- `MEM_WORDS` = 6000, host read at 6000: `mem_en` = 0 and the host read returns 8'hFF.
